// File: rtl/cu_isa_pkg.sv
// cu_isa_pkg: compute-unit ISA constants and sequencer state encoding
package cu_isa_pkg;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 8;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int TGT_MSB  = 11;
    localparam int TGT_LSB  = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 4;
    localparam int SRC1_MSB = 3;
    localparam int SRC1_LSB = 0;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} seq_state_t;
endpackage

// File: rtl/cu_instr_sequencer_if.sv
// cu_instr_sequencer_if: host, compute-unit and result-stream signals of the sequencer
interface cu_instr_sequencer_if #(parameter int AW = 4) ();
    logic          ena;
    logic          prog_clr;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic [7:0]    instr_hi;
    logic [7:0]    instr_lo;
    logic          cu_ena;
    logic [7:0]    result_in;
    logic          res_valid;
    logic [7:0]    res_data;
    logic [AW-1:0] res_idx;
    logic          res_ready;
    modport master (
        output ena, prog_clr, load_valid, load_byte, start, result_in, res_ready,
        input  load_ready, busy, done, instr_hi, instr_lo, cu_ena, res_valid, res_data, res_idx
    );
    modport slave (
        input  ena, prog_clr, load_valid, load_byte, start, result_in, res_ready,
        output load_ready, busy, done, instr_hi, instr_lo, cu_ena, res_valid, res_data, res_idx
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with occupancy count, push and pop in the same cycle
module sync_fifo #(
    parameter int W = 8,
    parameter int D = 4,
    localparam int PW = (D > 1) ? $clog2(D) : 1,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != CW'(D) || do_pop);
    assign dout_o  = mem_q[rp_q];
    assign valid_o = cnt_q != '0;
    assign count_o = cnt_q;

    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage, not reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/cu_instr_sequencer.sv
// cu_instr_sequencer: loads a byte-serial program, issues it to the compute unit, buffers results
module cu_instr_sequencer
    import cu_isa_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int RES_LAT = 2,
    parameter int FIFO_D  = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(FIFO_D + 1)
) (
    input logic clk,
    input logic rst_n,
    cu_instr_sequencer_if.slave bus
);
    seq_state_t           state_q;
    logic [INSTR_W-1:0]   mem_q [DEPTH];
    logic [AW:0]          cnt_q, pc_q;
    logic                 phase_q;
    logic [DATA_W-1:0]    hi_q, ihi_q, ilo_q;
    logic                 busy_q, done_q;
    logic [RES_LAT-1:0]   tv_q, tv_d;
    logic [AW-1:0]        ti_q [RES_LAT];
    logic [CW-1:0]        fcnt;
    logic [DATA_W+AW-1:0] fdout;
    logic                 fvalid, idle, load_acc, credit, issue, last, push;

    assign idle           = state_q == S_IDLE;
    assign bus.load_ready = idle && bus.ena && cnt_q != (AW + 1)'(DEPTH);
    assign load_acc       = bus.load_valid && bus.load_ready && !bus.prog_clr && !bus.start;
    // results already promised (in flight or buffered) must never exceed the FIFO
    assign credit         = ($countones(tv_q) + int'(fcnt)) < FIFO_D;
    assign issue          = state_q == S_RUN && bus.ena && credit;
    assign last           = (pc_q + 1'b1) == cnt_q;
    // bit 0 is the newest tag, the top bit is the one whose result is on result_in
    assign tv_d           = bus.ena ? RES_LAT'({tv_q, issue}) : tv_q;
    assign push           = bus.ena && tv_q[RES_LAT-1];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.instr_hi   = ihi_q;
    assign bus.instr_lo   = ilo_q;
    assign bus.cu_ena     = bus.ena;
    assign bus.res_valid  = fvalid;
    assign {bus.res_data, bus.res_idx} = fdout;

    // control FSM with registered busy/done/instruction outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ihi_q   <= '0;
            ilo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= bus.ena && state_q == S_DONE;
            if (bus.ena) begin
                {ihi_q, ilo_q} <= issue ? mem_q[pc_q[AW-1:0]] : '0;
                case (state_q)
                    S_IDLE: if (bus.start) begin
                        pc_q    <= '0;
                        state_q <= cnt_q == '0 ? S_DONE : S_RUN;
                        busy_q  <= cnt_q != '0;
                    end
                    S_RUN: if (issue) begin
                        pc_q <= pc_q + 1'b1;
                        if (last) state_q <= S_DRAIN;
                    end
                    S_DRAIN: if (tv_d == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                    S_DONE: state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // byte-serial loader: high byte is held until its low byte arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else if (bus.ena && idle && bus.prog_clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (bus.ena && idle && bus.start) begin
            phase_q <= 1'b0;
        end else if (load_acc) begin
            phase_q <= !phase_q;
            if (!phase_q) hi_q <= bus.load_byte;
            else cnt_q <= cnt_q + 1'b1;
        end
    end

    // program RAM write, contents survive reset
    always_ff @(posedge clk) begin
        if (load_acc && phase_q) mem_q[cnt_q[AW-1:0]] <= {hi_q, bus.load_byte};
    end

    // tag valid pipe
    always_ff @(posedge clk) begin
        if (!rst_n) tv_q <= '0;
        else tv_q <= tv_d;
    end

    // tag index pipe, only meaningful where the matching valid bit is set
    always_ff @(posedge clk) begin
        if (bus.ena) begin
            ti_q[0] <= pc_q[AW-1:0];
            for (int i = 1; i < RES_LAT; i++) ti_q[i] <= ti_q[i-1];
        end
    end

    sync_fifo #(.W(DATA_W + AW), .D(FIFO_D)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({bus.result_in, ti_q[RES_LAT-1]}),
        .pop_i   (bus.res_ready),
        .dout_o  (fdout),
        .valid_o (fvalid),
        .count_o (fcnt)
    );
endmodule
